// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: opcode map, FSM state type and
// default multi-cycle latencies.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    localparam int unsigned DEF_MUL_CYCLES = 4;
    localparam int unsigned DEF_DIV_CYCLES = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legality, execution latency and the
// divide-by-zero exception.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic [3:0]  opcode,
    input  logic [31:0] op_b,
    output logic        legal,
    output logic [3:0]  latency,
    output logic        div_by_zero
);

    // Single-cycle ops are the default; only MUL and DIV stretch the exec window.
    always_comb begin
        legal       = (opcode <= OP_DIV);
        div_by_zero = (opcode == OP_DIV) && (op_b == 32'd0);
        latency     = 4'd1;
        if (opcode == OP_MUL) begin
            latency = 4'(MUL_CYCLES);
        end else if (opcode == OP_DIV) begin
            latency = 4'(DIV_CYCLES);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: latches the request, holds the ALU
// execute window for the opcode's latency, captures the result and pulses done.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for req; operands latched on acceptance
//   ISSUE    | first exec cycle; counter loaded, single-cycle ops capture
//   WAIT     | remaining exec cycles of MUL/DIV; capture when counter is 1
//   DONE     | one-cycle done pulse, err reported for rejected requests
module alu_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req,
    input  logic [3:0]  opcode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  alu_opcode,
    output logic        alu_exec,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_result,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo
);

    seq_state_e  state_q, state_d;
    logic [3:0]  cnt_q;
    logic        err_q;

    logic [3:0]  dec_opcode;
    logic [31:0] dec_op_b;
    logic        legal;
    logic [3:0]  latency;
    logic        div_by_zero;
    logic        reject;

    // In IDLE the decoder classifies the incoming request; afterwards it
    // looks at the latched operation so the latency is known in ISSUE.
    assign dec_opcode = (state_q == ST_IDLE) ? opcode : alu_opcode;
    assign dec_op_b   = (state_q == ST_IDLE) ? op_b   : alu_b;
    assign reject     = !legal || div_by_zero;

    alu_op_decode #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_decode (
        .opcode      (dec_opcode),
        .op_b        (dec_op_b),
        .legal       (legal),
        .latency     (latency),
        .div_by_zero (div_by_zero)
    );

    // State register with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != ST_IDLE);
        done     = 1'b0;
        err      = 1'b0;
        alu_exec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = reject ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_exec = 1'b1;
                state_d  = (latency == 4'd1) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                alu_exec = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, exec down-counter and result capture.
    always_ff @(posedge clock) begin
        if (!clear) begin
            alu_opcode <= 4'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
            z_hi       <= 32'd0;
            z_lo       <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        alu_opcode <= opcode;
                        alu_a      <= op_a;
                        alu_b      <= op_b;
                        err_q      <= reject;
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= latency - 4'd1;
                    if (latency == 4'd1) begin
                        {z_hi, z_lo} <= alu_result;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        {z_hi, z_lo} <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 4, ALU exec cycles held for MUL (1..15).
REQ-002 Parameter DIV_CYCLES, default 8, ALU exec cycles held for DIV (1..15).
REQ-003 clock  in  1  single system clock; all state changes on rising edge.
REQ-004 clear  in  1  reset, synchronous, active-low.
REQ-005 req  in  1  control-unit operation request, sampled only in IDLE.
REQ-006 opcode  in  4  operation select (ADD 0000 .. DIV 1100).
REQ-007 op_a, op_b  in  32 each  operands A and B.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  error flag, valid only while done=1.
REQ-011 alu_opcode  out  4  opcode to ALU.
REQ-012 alu_exec  out  1  ALU execute enable.
REQ-013 alu_a, alu_b  out  32 each  operands to ALU.
REQ-014 alu_result  in  64  ALU result {HI, LO}.
REQ-015 z_hi, z_lo  out  32 each  captured result registers.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-017 Latency L: 1 for opcodes 0000-1010, MUL_CYCLES for 1011, DIV_CYCLES for 1100.
REQ-018 IDLE with req=1 at an edge: latch opcode, op_a and op_b into alu_opcode, alu_a and alu_b; go to ISSUE.
REQ-019 Exception: opcode 1101-1111, or DIV with op_b=0, goes to DONE with err=1; no exec, z unchanged.
REQ-020 ISSUE: alu_exec=1; load down-counter with L-1; if L=1, capture alu_result into {z_hi,z_lo} at that edge and go to DONE, else go to WAIT.
REQ-021 WAIT: alu_exec=1; operands and opcode held stable; counter decrements each edge.
REQ-022 WAIT: at the edge where the counter is 1, capture alu_result and go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, alu_exec=0, err=1 only for the REQ-019 cases; then go to IDLE.
REQ-024 Accepted request: done is high L+1 cycles after the req sampling edge.
REQ-025 Rejected request (REQ-019): done is high 1 cycle after the req sampling edge.
REQ-026 req in any state other than IDLE is ignored, not queued; minimum issue spacing is L+2 cycles.
REQ-027 z_hi and z_lo change only on a capture edge; they hold their value otherwise, including on error.
REQ-028 alu_exec is never high in IDLE or DONE.

Reset
REQ-029 clear=0 at an edge: state IDLE; busy, done, err and alu_exec 0; alu_opcode, alu_a, alu_b, z_hi and z_lo all 0; counter 0.
REQ-030 Reset during ISSUE or WAIT aborts the operation: no capture and no done pulse; clear dominates req.

Structure
REQ-031 Shared package alu_ctrl_pkg holds the 13 opcode constants, the FSM state type, and the default latencies.
REQ-032 One sub-module, alu_op_decode (combinational), maps opcode and op_b to three outputs: legal, latency, div_by_zero.

Verification
REQ-033 ADD: op_a=5, op_b=7 -> z_lo=12, z_hi=0, done 2 cycles after req, err=0.
REQ-034 MUL: op_a=0xFFFFFFFF, op_b=2 -> z_hi=0xFFFFFFFF, z_lo=0xFFFFFFFE; alu_exec high 4 cycles; done 5 cycles after req.
REQ-035 DIV: op_a=17, op_b=5 -> z_lo=3, z_hi=2, done 9 cycles after req.
REQ-036 Errors: DIV with op_b=0, and opcode 1111 -> done and err 1 cycle after req; z unchanged; alu_exec never high.
REQ-037 Reset mid-op: clear=0 during the 2nd WAIT cycle of a MUL -> z=0, no done, IDLE next cycle.
REQ-038 Busy handling: ADD req re-asserted during a MUL WAIT -> ignored; a new req in IDLE -> completes normally.
